// File: rtl/jt900h_pkg.sv
// Shared definitions for the TLCS-900H divider: default width and FSM encodings.
package jt900h_pkg;

    localparam int DIVN_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } divn_state_t;

endpackage

// File: rtl/jt900h_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module jt900h_div_step #(
    parameter int W = 16
)(
    input  logic [W-1:0] pr,
    input  logic [W-1:0] dvs,
    input  logic         din,
    output logic [W-1:0] pr_next,
    output logic         qbit
);

    logic [W:0] sh;

    always_comb begin
        sh      = {pr, din};
        qbit    = (sh >= {1'b0, dvs});
        // The difference is below the divisor whenever qbit is set, so W bits suffice.
        pr_next = qbit ? (sh[W-1:0] - dvs) : sh[W-1:0];
    end

endmodule

// File: rtl/jt900h_divn.sv
// Iterative restoring divider (2W/W or W/(W/2)), signed or unsigned, with overflow flag.
module jt900h_divn
    import jt900h_pkg::*;
#(
    parameter int W = DIVN_W
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic [2*W-1:0] op0,
    input  logic [W-1:0]   op1,
    input  logic           len,
    input  logic           sgn,
    input  logic           start,
    output logic [W-1:0]   quot,
    output logic [W-1:0]   rem,
    output logic           busy,
    output logic           done,
    output logic           v
);

    localparam int HW = W / 2;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] LIM_FULL = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] LIM_HALF = {{(HW+1){1'b0}}, {(HW-1){1'b1}}};

    divn_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  pr_q, pr_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  raw_q, raw_d;
    logic          len_q, len_d, sgn_q, sgn_d;
    logic          dvd_neg_q, dvd_neg_d, dvs_neg_q, dvs_neg_d;
    logic          ovf_q, ovf_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [W-1:0]  quot_q, quot_d, rem_q, rem_d;
    logic          v_q, v_d, done_q, done_d;

    logic [W-1:0]   step_pr;
    logic           step_qbit;
    logic           in_dvd_neg, in_dvs_neg;
    logic [2*W-1:0] in_dvd_mag;
    logic [W-1:0]   in_dvs_mag, in_hi, in_lo, in_half_dvd;
    logic [HW-1:0]  in_half_dvs;
    logic           q_neg, rng_ovf;
    logic [W-1:0]   lim_pos, lim_neg, q_fix, r_fix;
    logic [HW-1:0]  q_half, r_half;

    jt900h_div_step #(.W(W)) u_step (
        .pr      (pr_q),
        .dvs     (dvs_q),
        .din     (lo_q[W-1]),
        .pr_next (step_pr),
        .qbit    (step_qbit)
    );

    // Operand magnitudes and the early range check, evaluated on the start cycle.
    always_comb begin
        in_dvd_neg  = sgn & (len ? op0[2*W-1] : op0[W-1]);
        in_dvs_neg  = sgn & (len ? op1[W-1] : op1[HW-1]);
        in_half_dvd = in_dvd_neg ? -op0[W-1:0] : op0[W-1:0];
        in_half_dvs = in_dvs_neg ? -op1[HW-1:0] : op1[HW-1:0];
        if (len) begin
            in_dvd_mag = in_dvd_neg ? -op0 : op0;
            in_dvs_mag = in_dvs_neg ? -op1 : op1;
            in_hi      = in_dvd_mag[2*W-1:W];
            in_lo      = in_dvd_mag[W-1:0];
        end else begin
            in_dvd_mag = {{W{1'b0}}, in_half_dvd};
            in_dvs_mag = {{HW{1'b0}}, in_half_dvs};
            in_hi      = {{HW{1'b0}}, in_dvd_mag[W-1:HW]};
            in_lo      = {in_dvd_mag[HW-1:0], {HW{1'b0}}};
        end
    end

    // Sign application and final range check for the FIX cycle.
    always_comb begin
        q_neg   = dvd_neg_q ^ dvs_neg_q;
        lim_pos = len_q ? LIM_FULL : LIM_HALF;
        lim_neg = lim_pos + W'(1);
        rng_ovf = sgn_q & (q_neg ? (lo_q > lim_neg) : (lo_q > lim_pos));
        q_half  = q_neg ? -lo_q[HW-1:0] : lo_q[HW-1:0];
        r_half  = dvd_neg_q ? -pr_q[HW-1:0] : pr_q[HW-1:0];
        if (len_q) begin
            q_fix = q_neg ? -lo_q : lo_q;
            r_fix = dvd_neg_q ? -pr_q : pr_q;
        end else begin
            q_fix = {{HW{1'b0}}, q_half};
            r_fix = {{HW{1'b0}}, r_half};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pr_d      = pr_q;
        lo_d      = lo_q;
        raw_d     = raw_q;
        len_d     = len_q;
        sgn_d     = sgn_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        ovf_d     = ovf_q;
        dvs_d     = dvs_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        v_d       = v_q;
        done_d    = done_q;
        if (cen) begin
            done_d = 1'b0;
            case (state_q)
                ST_RUN: begin
                    pr_d  = step_pr;
                    lo_d  = {lo_q[W-2:0], step_qbit};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = ST_FIX;
                end
                ST_FIX: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    if (ovf_q || rng_ovf) begin
                        v_d    = 1'b1;
                        quot_d = len_q ? {W{1'b1}} : {{HW{1'b0}}, {HW{1'b1}}};
                        rem_d  = raw_q;
                    end else begin
                        v_d    = 1'b0;
                        quot_d = q_fix;
                        rem_d  = r_fix;
                    end
                end
                default: ;
            endcase
            // A start in any state (re)loads the operands; a running operation is dropped.
            if (start) begin
                state_d   = ST_RUN;
                cnt_d     = len ? CW'(W) : CW'(HW);
                pr_d      = in_hi;
                lo_d      = in_lo;
                dvs_d     = in_dvs_mag;
                raw_d     = len ? op0[W-1:0] : {{HW{1'b0}}, op0[HW-1:0]};
                len_d     = len;
                sgn_d     = sgn;
                dvd_neg_d = in_dvd_neg;
                dvs_neg_d = in_dvs_neg;
                ovf_d     = (in_hi >= in_dvs_mag);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pr_q      <= '0;
            lo_q      <= '0;
            raw_q     <= '0;
            len_q     <= 1'b0;
            sgn_q     <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            ovf_q     <= 1'b0;
            dvs_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            v_q       <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pr_q      <= pr_d;
            lo_q      <= lo_d;
            raw_q     <= raw_d;
            len_q     <= len_d;
            sgn_q     <= sgn_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            ovf_q     <= ovf_d;
            dvs_q     <= dvs_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            v_q       <= v_d;
            done_q    <= done_d;
        end
    end

    assign quot = quot_q;
    assign rem  = rem_q;
    assign v    = v_q;
    assign done = done_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jt900h_divn.sv
// Directed bench for jt900h_divn at W=16: hand-computed quotients, remainders, flags and latency.
module tb_jt900h_divn;

    logic        clk = 1'b0;
    logic        rst, cen, len, sgn, start;
    logic [31:0] op0;
    logic [15:0] op1;
    logic [15:0] quot, rem;
    logic        busy, done, v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jt900h_divn #(.W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .cen   (cen),
        .op0   (op0),
        .op1   (op1),
        .len   (len),
        .sgn   (sgn),
        .start (start),
        .quot  (quot),
        .rem   (rem),
        .busy  (busy),
        .done  (done),
        .v     (v)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one division and follow it to its done pulse.
    // cen_div > 1 enables only one edge in cen_div after the start edge.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [15:0] b,
                          input logic l, input logic s, input int cen_div,
                          input logic [15:0] eq, input logic [15:0] er, input logic ev,
                          input int exp_lat);
        int   en_edges = 0;
        int   busy_cnt = 1;
        int   done_cnt = 0;
        logic seen = 1'b0;
        logic hold_bad = 1'b0;
        logic [15:0] prev_q;
        prev_q = quot;
        @(negedge clk);
        op0 = a; op1 = b; len = l; sgn = s; start = 1'b1; cen = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            cen = ((i % cen_div) == (cen_div - 1));
            @(posedge clk); #1;
            if (cen) begin
                en_edges++;
                if (busy) busy_cnt++;
                if (done) begin
                    seen = 1'b1;
                    done_cnt++;
                end
            end
            if (!seen && quot !== prev_q) hold_bad = 1'b1;
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(en_edges), 32'(exp_lat));
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        chk({tag, " hold_during_run"}, 32'(hold_bad), 32'd0);
        chk({tag, " quot"}, 32'(quot), 32'(eq));
        chk({tag, " rem"}, 32'(rem), 32'(er));
        chk({tag, " v"}, 32'(v), 32'(ev));
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        $display("op %s: op0=%h op1=%h len=%0d sgn=%0d -> quot=%h rem=%h v=%0d lat=%0d",
                 tag, a, b, l, s, quot, rem, v, en_edges);
        if (cen_div > 1) begin
            @(negedge clk); cen = 1'b0;
            @(posedge clk); #1;
            chk({tag, " done_stretch"}, 32'(done), 32'd1);
        end
        @(negedge clk); cen = 1'b1;
        @(posedge clk); #1;
        chk({tag, " done_single"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic spurious;
        rst = 1'b1; cen = 1'b1; len = 1'b1; sgn = 1'b0; start = 1'b0;
        op0 = '0; op1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset quot", 32'(quot), 32'd0);
        chk("reset rem", 32'(rem), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset v", 32'(v), 32'd0);
        @(negedge clk); rst = 1'b0;

        run_op("udiv_full", 32'h0001_2345, 16'h0100, 1'b1, 1'b0, 1, 16'h0123, 16'h0045, 1'b0, 17);
        run_op("udiv_half", 32'h0000_1234, 16'h0056, 1'b0, 1'b0, 1, 16'h0036, 16'h0010, 1'b0, 9);
        run_op("sdiv_full", 32'hFFFF_FF9C, 16'h0007, 1'b1, 1'b1, 1, 16'hFFF2, 16'hFFFE, 1'b0, 17);
        run_op("sdiv_half", 32'h0000_FF9C, 16'h0007, 1'b0, 1'b1, 1, 16'h00F2, 16'h00FE, 1'b0, 9);
        run_op("div_zero", 32'h0000_ABCD, 16'h0000, 1'b1, 1'b0, 1, 16'hFFFF, 16'hABCD, 1'b1, 17);
        run_op("uovf", 32'h0002_0000, 16'h0002, 1'b1, 1'b0, 1, 16'hFFFF, 16'h0000, 1'b1, 17);
        run_op("sovf_pos", 32'h0000_8000, 16'h0001, 1'b1, 1'b1, 1, 16'hFFFF, 16'h8000, 1'b1, 17);
        run_op("s_minneg", 32'hFFFF_8000, 16'h0001, 1'b1, 1'b1, 1, 16'h8000, 16'h0000, 1'b0, 17);
        run_op("cen_1of3", 32'h0001_2345, 16'h0100, 1'b1, 1'b0, 3, 16'h0123, 16'h0045, 1'b0, 17);

        // Start an operation that would flag overflow, then restart it at step 5.
        @(negedge clk);
        op0 = 32'h0000_ABCD; op1 = 16'h0000; len = 1'b1; sgn = 1'b0; start = 1'b1; cen = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        spurious = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) spurious = 1'b1;
        end
        chk("abort no_early_done", 32'(spurious), 32'd0);
        run_op("abort_restart", 32'h0000_1234, 16'h0056, 1'b0, 1'b0, 1, 16'h0036, 16'h0010, 1'b0, 9);

        // Reset in the middle of a full-mode operation.
        @(negedge clk);
        op0 = 32'h0000_ABCD; op1 = 16'h0000; len = 1'b1; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst quot", 32'(quot), 32'd0);
        chk("midrst rem", 32'(rem), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst v", 32'(v), 32'd0);
        @(negedge clk); rst = 1'b0;
        spurious = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done || busy) spurious = 1'b1;
        end
        chk("midrst no_done_after", 32'(spurious), 32'd0);
        $display("op midrst: quot=%h rem=%h busy=%0d done=%0d v=%0d", quot, rem, busy, done, v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
